// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e   - 2-bit sequencer state encoding (RUN/STALL/DELAY/REDIRECT)
//   NOP_INSTR       - instruction word substituted into decode while stalled/held
//   NOP_BUNDLE      - control bundle substituted into decode while stalled/held
//   STALL_W_DEFAULT - default width of stall length / stall counter
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StStall    = 2'd1,
        StDelay    = 2'd2,
        StRedirect = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h3400_0000;
    localparam logic [23:0] NOP_BUNDLE = 24'h0E_2531;

    localparam int unsigned STALL_W_DEFAULT = 4;

endpackage

// File: rtl/stall_down_counter.sv
// stall_down_counter: loadable down counter that saturates at zero.
//   clk, reset       - clock, asynchronous active-high reset (count -> 0)
//   hold             - freeze count (dominates load and dec)
//   load, load_val   - load a new count
//   dec              - decrement by one; no effect once the count is zero
//   count            - current count
//   is_zero, is_one  - terminal-condition flags
module stall_down_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic [Width-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!hold) begin
            if (load) begin
                count_d = load_val;
            end else if (dec && (count_q != '0)) begin
                count_d = count_q - Width'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == Width'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore controller for the instruction-fetch stage.
//   clk, reset      - clock, asynchronous active-high reset
//   stall_req       - multi-cycle stall request (sampled in RUN only)
//   stall_len       - requested stall cycles; 0 means no stall
//   jump_branch_in  - taken jump/branch resolved this cycle (sampled in RUN only)
//   ext_hold        - external freeze; forces a bubble and freezes all state
//   pc_en           - PC / PC+4 / jump-flag register enable
//   nop_sel         - substitute NOP instruction and NOP bundle into decode
//   restore_sel     - take next PC from the saved sequential PC
//   stall_cnt       - remaining stall cycles (0 outside STALL)
//   busy            - state is not RUN
//   state_out       - current state, for debug
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned STALL_W = STALL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_req,
    input  logic [STALL_W-1:0] stall_len,
    input  logic               jump_branch_in,
    input  logic               ext_hold,
    output logic               pc_en,
    output logic               nop_sel,
    output logic               restore_sel,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               busy,
    output logic [1:0]         state_out
);

    fetch_state_e state_q, state_d;
    logic         pending_jb_q, pending_jb_d;

    logic               cnt_load;
    logic               cnt_dec;
    logic [STALL_W-1:0] cnt_value;
    logic               cnt_is_zero;
    logic               cnt_is_one;

    stall_down_counter #(
        .Width (STALL_W)
    ) u_stall_cnt (
        .clk      (clk),
        .reset    (reset),
        .hold     (ext_hold),
        .load     (cnt_load),
        .load_val (stall_len),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .is_zero  (cnt_is_zero),
        .is_one   (cnt_is_one)
    );

    // Next-state logic. Under ext_hold nothing is sampled and nothing moves.
    always_comb begin
        state_d      = state_q;
        pending_jb_d = pending_jb_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        if (!ext_hold) begin
            case (state_q)
                StRun: begin
                    if (stall_req && (stall_len != '0)) begin
                        // A jump arriving with the stall is serviced once the stall ends.
                        cnt_load     = 1'b1;
                        state_d      = StStall;
                        pending_jb_d = jump_branch_in;
                    end else if (jump_branch_in) begin
                        state_d = StDelay;
                    end
                end
                StStall: begin
                    cnt_dec = 1'b1;
                    // is_zero cannot occur in STALL; treated as terminal so STALL never sticks.
                    if (cnt_is_one || cnt_is_zero) begin
                        state_d      = pending_jb_q ? StDelay : StRun;
                        pending_jb_d = 1'b0;
                    end
                end
                StDelay:    state_d = StRedirect;
                StRedirect: state_d = StRun;
                default:    state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pending_jb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_jb_q <= pending_jb_d;
        end
    end

    // Outputs depend on state and ext_hold only.
    always_comb begin
        pc_en       = 1'b1;
        nop_sel     = 1'b0;
        restore_sel = 1'b0;
        if (ext_hold) begin
            pc_en   = 1'b0;
            nop_sel = 1'b1;
        end else begin
            case (state_q)
                StRun:      pc_en = 1'b1;
                StStall: begin
                    pc_en   = 1'b0;
                    nop_sel = 1'b1;
                end
                StDelay:    pc_en = 1'b1;
                StRedirect: restore_sel = 1'b1;
                default:    pc_en = 1'b1;
            endcase
        end
    end

    assign stall_cnt = (state_q == StStall) ? cnt_value : '0;
    assign busy      = (state_q != StRun);
    assign state_out = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven check of fetch_sequencer plus two hand-written
// multi-cycle sequences. Each table row is one clock cycle: inputs driven during
// the cycle and the outputs expected during that same cycle.
module tb_fetch_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall_req;
    logic [W-1:0] stall_len;
    logic         jump_branch_in;
    logic         ext_hold;
    logic         pc_en;
    logic         nop_sel;
    logic         restore_sel;
    logic [W-1:0] stall_cnt;
    logic         busy;
    logic [1:0]   state_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .STALL_W (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_req      (stall_req),
        .stall_len      (stall_len),
        .jump_branch_in (jump_branch_in),
        .ext_hold       (ext_hold),
        .pc_en          (pc_en),
        .nop_sel        (nop_sel),
        .restore_sel    (restore_sel),
        .stall_cnt      (stall_cnt),
        .busy           (busy),
        .state_out      (state_out)
    );

    typedef struct {
        logic         r;
        logic         sr;
        logic [W-1:0] len;
        logic         jb;
        logic         h;
        logic         pc;
        logic         nop;
        logic         rs;
        logic [W-1:0] cnt;
        logic         bz;
        logic [1:0]   st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic sr, input int len, input logic jb,
                                input logic h, input logic pc, input logic nop, input logic rs,
                                input int cnt, input logic bz, input int st);
        vec_t v;
        v.r   = r;
        v.sr  = sr;
        v.len = W'(len);
        v.jb  = jb;
        v.h   = h;
        v.pc  = pc;
        v.nop = nop;
        v.rs  = rs;
        v.cnt = W'(cnt);
        v.bz  = bz;
        v.st  = 2'(st);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sr, input logic [W-1:0] len,
                         input logic jb, input logic h);
        reset          = r;
        stall_req      = sr;
        stall_len      = len;
        jump_branch_in = jb;
        ext_hold       = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int low_cycles;
        // Cols: reset stall_req len jb hold | pc_en nop restore cnt busy state
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));  // reset
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Stall of 3
        vecs.push_back(mk(0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Plain jump
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Stall 2 together with jump
        vecs.push_back(mk(0, 1, 2, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Hold for 2 cycles in REDIRECT
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Zero-length stall ignored, jump in DELAY ignored, stall in REDIRECT ignored
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 5, 0, 0,  1, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Hold inside STALL freezes the counter
        vecs.push_back(mk(0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Reset mid-STALL (counter 3) with a pending jump: jump dropped
        vecs.push_back(mk(0, 1, 3, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 3, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Hold in RUN: requests not sampled
        vecs.push_back(mk(0, 1, 2, 1, 1,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Reset together with hold
        vecs.push_back(mk(1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        // Maximum stall length
        vecs.push_back(mk(0, 1, 15, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 15, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 14, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));

        // Produce a clean rising edge on reset before the first clock.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("reset_pc_en", -1, 32'(pc_en), 32'd1);
        check("reset_state", -1, 32'(state_out), 32'd0);
        check("reset_busy", -1, 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].sr, vecs[i].len, vecs[i].jb, vecs[i].h);
            #1;
            check("pc_en", i, 32'(pc_en), 32'(vecs[i].pc));
            check("nop_sel", i, 32'(nop_sel), 32'(vecs[i].nop));
            check("restore_sel", i, 32'(restore_sel), 32'(vecs[i].rs));
            check("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].cnt));
            check("busy", i, 32'(busy), 32'(vecs[i].bz));
            check("state_out", i, 32'(state_out), 32'(vecs[i].st));
        end

        // Stall of 7: count bubble cycles, bounded.
        @(negedge clk);
        drive(1'b0, 1'b1, W'(7), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check("stall7_first_cnt", -1, 32'(stall_cnt), 32'd7);
        low_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (pc_en) break;
            low_cycles++;
            @(negedge clk);
            #1;
        end
        check("stall7_bubble_cycles", -1, 32'(low_cycles), 32'd7);

        // Hold raised mid-cycle in REDIRECT acts combinationally.
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("redir_restore", -1, 32'(restore_sel), 32'd1);
        ext_hold = 1'b1;
        #1;
        check("redir_held_restore", -1, 32'(restore_sel), 32'd0);
        check("redir_held_pc_en", -1, 32'(pc_en), 32'd0);
        ext_hold = 1'b0;
        #1;
        check("redir_release_restore", -1, 32'(restore_sel), 32'd1);
        @(negedge clk);
        #1;
        check("redir_then_run", -1, 32'(state_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Moore-style controller that sequences the instruction-fetch stage: it owns the PC write enable, the NOP-substitution select and the jump/branch sequential-PC restore select. It replaces the ad-hoc stall and jump/branch flag registers around the fetch datapath with one explicit state machine. It adds multi-cycle stall counting, delay-slot sequencing and an external hold. It sits between the decode/control logic (stall requests, resolved jumps) and the fetch datapath (PC registers, NOP muxes, restore mux).

## Interface
- STALL_W, 4, width of stall length and stall counter

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- stall_req  in  1  decoded instruction requests a multi-cycle stall; sampled only in RUN
- stall_len  in  STALL_W  number of stall cycles requested; 0 = no stall
- jump_branch_in  in  1  taken jump/branch resolved this cycle
- ext_hold  in  1  external freeze (e.g. data memory busy)
- pc_en  out  1  PC / PC+4 / jump-flag register enable
- nop_sel  out  1  1 = drive NOP instruction 0x34000000 and NOP bundle 0x0E2531 to decode
- restore_sel  out  1  1 = next PC taken from saved sequential PC
- stall_cnt  out  STALL_W  remaining stall cycles
- busy  out  1  state != RUN
- state_out  out  2  current state, for debug

## Operation
- States: RUN=0, STALL=1, DELAY=2, REDIRECT=3.
- State-driven outputs when ext_hold=0:
  - RUN: pc_en=1, nop_sel=0, restore_sel=0.
  - STALL: pc_en=0, nop_sel=1.
  - DELAY: pc_en=1, nop_sel=0.
  - REDIRECT: pc_en=1, restore_sel=1.
- RUN, stall_req=1 and stall_len=N>0: load counter with N, go to STALL.
- RUN, stall_req=1 with stall_len=0: ignored.
- RUN, jump_branch_in=1, no stall: go to DELAY. The delay-slot instruction is fetched normally.
- DELAY always goes to REDIRECT. REDIRECT always goes to RUN.
- STALL: counter decrements each cycle. When the counter is 1, it goes to 0 and the state moves to RUN. If pending_jb=1, the state moves to DELAY instead and pending_jb is cleared.
- A RUN cycle with both stall_req (N>0) and jump_branch_in: enter STALL and set pending_jb=1. The jump is serviced after the stall.
- jump_branch_in in STALL, DELAY or REDIRECT: ignored. A jump in a delay slot is illegal.
- stall_req outside RUN: ignored.
- ext_hold=1 overrides every state:
  - pc_en=0, nop_sel=1, restore_sel=0.
  - State, counter and pending_jb are frozen.
  - Inputs are not sampled.
- Counter arithmetic is unsigned, STALL_W bits. It never decrements below 0 and never wraps.
- stall_cnt = counter value; it is 0 outside STALL.

## Timing
- Reset values: state RUN, counter 0, pending_jb 0.
- Outputs under reset: pc_en=1 (0 if ext_hold), nop_sel=0, restore_sel=0, stall_cnt=0, busy=0, state_out=0.
- Reset asserted mid-operation: return to RUN on the same edge; any pending jump is dropped.
- Outputs are combinational from state and ext_hold only. There is no input-to-output combinational path except ext_hold.
- Stall request sampled at edge t with N: pc_en=0 and nop_sel=1 for exactly N cycles (t+1..t+N); pc_en=1 from t+N+1.
- Jump sampled at edge t: DELAY in cycle t+1, REDIRECT (restore_sel=1 for exactly one cycle) in t+2, RUN in t+3.
- Jump plus stall N at edge t: STALL t+1..t+N, DELAY t+N+1, REDIRECT t+N+2.
- An ext_hold of H cycles extends any of the above sequences by exactly H cycles.

## Structure
- Package fetch_seq_pkg holds:
  - the state enum (2 bits)
  - NOP_INSTR = 32'h34000000 and NOP_BUNDLE = 24'h0E2531
  - the default STALL_W
- One sub-module: stall_down_counter.
  - Parameterized width; load and decrement enables plus hold.
  - Provides a zero/one flag for the terminal condition.
- The FSM and output decode live in fetch_sequencer.

## Test plan
- Reset pulsed mid-STALL (counter=3) → next cycle state_out=0, stall_cnt=0, pc_en=1, busy=0.
- stall_req=1, stall_len=3 in RUN → pc_en=0 and nop_sel=1 for 3 cycles, stall_cnt 3,2,1, then pc_en=1.
- jump_branch_in=1 in RUN → state sequence DELAY, REDIRECT, RUN; restore_sel high only in REDIRECT; pc_en=1 throughout.
- stall_req=1 (len 2) and jump_branch_in=1 in the same cycle → STALL ×2, DELAY, REDIRECT, RUN.
- ext_hold=1 for 2 cycles during REDIRECT → pc_en=0 and restore_sel=0 while held; REDIRECT is then reasserted for one cycle.
- stall_req=1 with stall_len=0, and jump_branch_in=1 during DELAY → both ignored; outputs match plain RUN/DELAY behavior.
